// File: rtl/pingpong_obuf.sv
// Double-banked PPU output buffer.
// One bank fills from the PPU while the other drains over valid/ready.
module pingpong_obuf #(
  parameter int LANES  = 16,
  parameter int ELEM_W = 4,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_we,
  input  logic [ADDR_W-1:0]         i_addr,
  input  logic [LANES*ELEM_W-1:0]   i_data,
  input  logic                      i_wlast,
  output logic                      o_wr_ready,
  output logic                      o_wr_err,
  output logic                      o_rd_valid,
  input  logic                      i_rd_ready,
  output logic [LANES*ELEM_W-1:0]   o_rd_data,
  output logic                      o_rd_last,
  output logic [1:0]                o_bank_full
);

  localparam int W = LANES * ELEM_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_st_e;

  bank_st_e          st_q [2];
  bank_st_e          st_d [2];
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic [W-1:0]      rd_data_q, rd_data_d;
  logic              wr_err_q, wr_err_d;
  logic [W-1:0]      mem_q [2*DEPTH];

  logic wr_ready;
  logic we_ok;
  logic hs;
  logic hs_last;
  logic rb;
  logic issue;

  // Bank state machine, read issue and output slot next-state
  always_comb begin
    st_d       = st_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    rd_ptr_d   = rd_ptr_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_data_d  = rd_data_q;

    wr_ready = (st_q[wr_bank_q] == EMPTY) ||
               (st_q[wr_bank_q] == FILLING);
    we_ok    = i_we & wr_ready;
    wr_err_d = wr_err_q | (i_we & ~wr_ready);

    hs      = rd_valid_q & i_rd_ready;
    hs_last = hs & rd_last_q;
    // On the final handshake the next read comes from the other bank
    rb      = hs_last ? ~rd_bank_q : rd_bank_q;
    issue   = ((st_q[rb] == FULL) || (st_q[rb] == DRAINING)) &&
              (~rd_valid_q || i_rd_ready);

    if (we_ok) begin
      if (i_wlast) begin
        st_d[wr_bank_q] = FULL;
        wr_bank_d       = ~wr_bank_q;
      end else if (st_q[wr_bank_q] == EMPTY) begin
        st_d[wr_bank_q] = FILLING;
      end
    end

    if (hs_last) begin
      st_d[rd_bank_q] = EMPTY;
      rd_bank_d       = ~rd_bank_q;
    end

    if (issue) begin
      if (rd_ptr_q == '0) st_d[rb] = DRAINING;
      rd_ptr_d   = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      rd_valid_d = 1'b1;
      rd_last_d  = (rd_ptr_q == LAST);
      rd_data_d  = mem_q[{rb, rd_ptr_q}];
    end else if (hs) begin
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st_q[0]    <= EMPTY;
      st_q[1]    <= EMPTY;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      st_q[0]    <= st_d[0];
      st_q[1]    <= st_d[1];
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // Bank storage; contents survive reset
  always_ff @(posedge i_clk) begin
    if (we_ok) mem_q[{wr_bank_q, i_addr}] <= i_data;
  end

  assign o_wr_ready  = wr_ready;
  assign o_wr_err    = wr_err_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = rd_data_q;
  assign o_rd_last   = rd_last_q;
  assign o_bank_full = {(st_q[1] == FULL) || (st_q[1] == DRAINING),
                        (st_q[0] == FULL) || (st_q[0] == DRAINING)};

endmodule

// File: tb/tb_pingpong_obuf.sv
// Directed bench for pingpong_obuf with a drain scoreboard.
// Covers INT4/64-deep default and an INT8/32-deep instance.
module tb_pingpong_obuf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        we, wlast, wr_ready, wr_err;
  logic [5:0]  addr;
  logic [63:0] wdata, rd_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [1:0]  bank_full;

  logic         we8, wlast8, wr_ready8, wr_err8;
  logic [4:0]   addr8;
  logic [127:0] wdata8, rd_data8;
  logic         rd_valid8, rd_ready8, rd_last8;
  logic [1:0]   bank_full8;

  pingpong_obuf dut (
    .i_clk(clk), .i_rst(rst),
    .i_we(we), .i_addr(addr), .i_data(wdata), .i_wlast(wlast),
    .o_wr_ready(wr_ready), .o_wr_err(wr_err),
    .o_rd_valid(rd_valid), .i_rd_ready(rd_ready),
    .o_rd_data(rd_data), .o_rd_last(rd_last),
    .o_bank_full(bank_full)
  );

  pingpong_obuf #(.LANES(16), .ELEM_W(8), .DEPTH(32), .ADDR_W(5)) dut8 (
    .i_clk(clk), .i_rst(rst),
    .i_we(we8), .i_addr(addr8), .i_data(wdata8), .i_wlast(wlast8),
    .o_wr_ready(wr_ready8), .o_wr_err(wr_err8),
    .o_rd_valid(rd_valid8), .i_rd_ready(rd_ready8),
    .o_rd_data(rd_data8), .o_rd_last(rd_last8),
    .o_bank_full(bank_full8)
  );

  int total = 0;
  int passed = 0;
  int hs_cnt = 0;
  int hs8 = 0;
  logic [64:0]  q [$];
  logic [128:0] q8 [$];
  logic [63:0]  shadow [64];

  task automatic chk(input string tag, input logic [128:0] obs,
                     input logic [128:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] pat(input int s, input int i);
    logic [15:0] v;
    v = 16'(s * 256 + i);
    return {4{v}};
  endfunction

  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      if (q.size() == 0) chk("sb_underflow", 129'(q.size()), 129'(1));
      else chk("rd_word", 129'({rd_last, rd_data}), 129'(q.pop_front()));
      hs_cnt++;
    end
    if (!rst && rd_valid8 && rd_ready8) begin
      if (q8.size() == 0) chk("sb8_underflow", 129'(q8.size()), 129'(1));
      else chk("rd8_word", {rd_last8, rd_data8}, q8.pop_front());
      hs8++;
    end
  end

  task automatic wr(input int a, input logic [63:0] d, input logic last);
    we = 1'b1; addr = 6'(a); wdata = d; wlast = last;
    @(posedge clk); #1;
    we = 1'b0; wlast = 1'b0;
    shadow[a] = d;
    if (last)
      for (int i = 0; i < 64; i++) q.push_back({i == 63, shadow[i]});
  endtask

  task automatic fill(input int s);
    for (int i = 0; i < 64; i++) wr(i, pat(s, i), i == 63);
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    chk(tag, 129'(q.size()), 129'(0));
  endtask

  task automatic wait_hs(input string tag, input int target);
    int n = 0;
    while (hs_cnt < target && n < 400) begin
      @(posedge clk); #1; n++;
    end
    chk(tag, 129'(hs_cnt), 129'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int h0;
    int n;
    rst = 1'b1; we = 0; wlast = 0; addr = 0; wdata = 0; rd_ready = 0;
    we8 = 0; wlast8 = 0; addr8 = 0; wdata8 = 0; rd_ready8 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_valid", 129'(rd_valid), 129'(0));
    chk("rst_wr_ready", 129'(wr_ready), 129'(1));
    chk("rst_bank_full", 129'(bank_full), 129'(0));
    chk("rst_wr_err", 129'(wr_err), 129'(0));
    chk("rst_data", 129'({rd_last, rd_data}), 129'(0));

    // Fill bank 0 then drain without stalls
    rd_ready = 1'b1;
    h0 = hs_cnt;
    fill(1);
    chk("t1_lat1_valid", 129'(rd_valid), 129'(0));
    chk("t1_bank_full", 129'(bank_full), 129'(2'b01));
    chk("t1_wr_ready", 129'(wr_ready), 129'(1));
    @(posedge clk); #1;
    chk("t1_lat2_valid", 129'(rd_valid), 129'(1));
    repeat (63) @(posedge clk);
    #1;
    chk("t1_last_at_63", 129'({rd_valid, rd_last}), 129'(2'b11));
    @(posedge clk); #1;
    chk("t1_drained", 129'(q.size()), 129'(0));
    chk("t1_hs_count", 129'(hs_cnt - h0), 129'(64));
    chk("t1_idle", 129'({rd_valid, bank_full}), 129'(0));

    // Stall the consumer for 5 cycles with word 10 in the slot
    h0 = hs_cnt;
    fill(2);
    wait_hs("t2_reach10", h0 + 10);
    rd_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t2_hold", 129'({rd_valid, rd_data}), 129'({1'b1, pat(2, 10)}));
      @(posedge clk); #1;
    end
    rd_ready = 1'b1;
    wait_empty("t2_drained");
    @(posedge clk); #1;
    chk("t2_hs_count", 129'(hs_cnt - h0), 129'(64));

    // Overwrite address 5; last write wins
    wr(5, {16{4'hA}}, 1'b0);
    for (int i = 0; i < 63; i++) if (i != 5) wr(i, pat(3, i), 1'b0);
    wr(5, {16{4'hB}}, 1'b0);
    wr(63, pat(3, 63), 1'b1);
    wait_empty("t4_drained");
    @(posedge clk); #1;

    // Both banks full under back-pressure
    rd_ready = 1'b0;
    fill(4);
    fill(5);
    chk("t3_both_full", 129'(bank_full), 129'(2'b11));
    chk("t3_wr_ready", 129'(wr_ready), 129'(0));
    we = 1'b1; wlast = 1'b1; addr = 6'd3; wdata = '1;
    @(posedge clk); #1;
    we = 1'b0; wlast = 1'b0;
    chk("t3_err_set", 129'(wr_err), 129'(1));
    chk("t3_full_kept", 129'(bank_full), 129'(2'b11));
    repeat (3) @(posedge clk);
    #1;
    chk("t3_err_sticky", 129'(wr_err), 129'(1));
    rd_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(rd_valid && rd_last) && n < 200);
    chk("t3_pre_last_ready", 129'({rd_valid, rd_last, wr_ready}), 129'(3'b110));
    @(posedge clk); #1;
    chk("t3_post_last_ready", 129'(wr_ready), 129'(1));
    chk("t3_one_full", 129'(bank_full), 129'(2'b01));
    wait_empty("t3_drained");
    @(posedge clk); #1;
    chk("t3_err_end", 129'(wr_err), 129'(1));

    // Reset during a drain at word 30
    h0 = hs_cnt;
    fill(6);
    wait_hs("t5_reach30", h0 + 30);
    rd_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    chk("t5_valid", 129'(rd_valid), 129'(0));
    chk("t5_bank_full", 129'(bank_full), 129'(0));
    chk("t5_wr_ready", 129'(wr_ready), 129'(1));
    chk("t5_err_clr", 129'(wr_err), 129'(0));
    chk("t5_out_clr", 129'({rd_last, rd_data}), 129'(0));
    rd_ready = 1'b1;
    h0 = hs_cnt;
    fill(7);
    wait_empty("t5_new_drained");
    @(posedge clk); #1;
    chk("t5_hs_count", 129'(hs_cnt - h0), 129'(64));

    // INT8, 32-deep instance
    rd_ready8 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      we8 = 1'b1; addr8 = 5'(i);
      wdata8 = {16{8'(i + 64)}};
      wlast8 = (i == 31);
      q8.push_back({i == 31, wdata8});
      @(posedge clk); #1;
      we8 = 1'b0; wlast8 = 1'b0;
    end
    chk("t6_lat1_valid", 129'(rd_valid8), 129'(0));
    @(posedge clk); #1;
    chk("t6_lat2_valid", 129'(rd_valid8), 129'(1));
    n = 0;
    while (q8.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("t6_drained", 129'(q8.size()), 129'(0));
    chk("t6_hs_count", 129'(hs8), 129'(32));
    chk("t6_err", 129'(wr_err8), 129'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
